// File: rtl/pixel_frame_writer_pkg.sv
// Shared definitions for the pixel frame writer: FSM state encoding,
// default frame geometry, pixel width and the RAM address width.
package pixel_frame_writer_pkg;

  localparam int WIDTH_DEF  = 6;
  localparam int HEIGHT_DEF = 6;
  localparam int COL_SZ     = 3;
  localparam int ADDR_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_frame_writer_if.sv
// Pixel stream handshake plus pixel RAM write port of the frame writer.
// master: the environment (pixel source / RAM side); slave: the writer.
interface pixel_frame_writer_if
  import pixel_frame_writer_pkg::*;
#(
  parameter int colSz  = COL_SZ,
  parameter int ADDR_BITS = ADDR_W
) ();

  logic [colSz-1:0]     pixIn;
  logic                 pixValid;
  logic                 pixReady;
  logic [ADDR_BITS-1:0] wrAddr;
  logic [colSz-1:0]     wrData;
  logic                 wrEn;

  modport master (
    output pixIn, pixValid,
    input  pixReady, wrAddr, wrData, wrEn
  );

  modport slave (
    input  pixIn, pixValid,
    output pixReady, wrAddr, wrData, wrEn
  );

endinterface

// File: rtl/pixel_frame_writer_addr_xlate.sv
// Raster address translation: addr = y*WIDTH + x, unsigned and
// zero-extended. The default 6-pixel-wide frame uses y*4 + y*2 + x.
module pix_addr_xlate
  import pixel_frame_writer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int XW    = 3,
  parameter int YW    = 3,
  parameter int AW    = ADDR_W
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [AW-1:0] addr
);

  generate
    if (WIDTH == 6) begin : g_shift_add
      assign addr = (AW'(y) << 2) + (AW'(y) << 1) + AW'(x);
    end else begin : g_mult
      assign addr = AW'(y) * AW'(WIDTH) + AW'(x);
    end
  endgenerate

endmodule

// File: rtl/pixel_frame_writer.sv
// Pixel frame writer: accepts one frame of raster-order pixels over a
// valid/ready handshake and writes each to pixel RAM one cycle later.
// Optional feature macro: PIX_BINARISE_EN (threshold pixels to 0 / all-ones).
module pixel_frame_writer
  import pixel_frame_writer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int HEIGHT    = HEIGHT_DEF,
  parameter int colSz     = COL_SZ,
  parameter int THRESHOLD = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  output logic                 busy,
  output logic                 frameDone,
  pixel_frame_writer_if.slave  pix
);

  localparam int XW = cnt_w(WIDTH);
  localparam int YW = cnt_w(HEIGHT);

  state_t              state_reg;
  state_t              state_next;
  logic [XW-1:0]       x_reg;
  logic [YW-1:0]       y_reg;
  logic                accept;
  logic                last_pix;
  logic                pix_ready;
  logic [ADDR_W-1:0]   addr_calc;
  logic [colSz-1:0]    data_mapped;
  logic                wr_en_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [colSz-1:0]    wr_data_reg;

  assign last_pix = (x_reg == XW'(WIDTH - 1)) && (y_reg == YW'(HEIGHT - 1));

  pix_addr_xlate #(
    .WIDTH (WIDTH),
    .XW    (XW),
    .YW    (YW),
    .AW    (ADDR_W)
  ) u_addr (
    .x    (x_reg),
    .y    (y_reg),
    .addr (addr_calc)
  );

`ifdef PIX_BINARISE_EN
  localparam logic [colSz-1:0] THRESH = colSz'(THRESHOLD);
  // Binarise: anything above the threshold becomes full intensity.
  always_comb begin
    data_mapped = (pix.pixIn > THRESH) ? '1 : '0;
  end
`else
  // Pass-through pixel data.
  always_comb begin
    data_mapped = pix.pixIn;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // FSM next state and handshake/status outputs.
  always_comb begin
    state_next = state_reg;
    pix_ready  = 1'b0;
    busy       = 1'b0;
    frameDone  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        accept    = pix.pixValid;
        if (pix.pixValid && last_pix) state_next = ST_DONE;
      end
      ST_DONE: begin
        // Final write is on the bus this cycle; the frame is complete.
        busy       = 1'b1;
        frameDone  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign pix.pixReady = pix_ready;

  // Raster x/y counters: cleared on frame start, advanced per accepted pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (state_reg == ST_IDLE && start) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (accept) begin
      if (x_reg == XW'(WIDTH - 1)) begin
        x_reg <= '0;
        y_reg <= (y_reg == YW'(HEIGHT - 1)) ? '0 : y_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

  // Registered RAM write port, one cycle after acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= accept;
      if (accept) begin
        wr_addr_reg <= addr_calc;
        wr_data_reg <= data_mapped;
      end
    end
  end

  assign pix.wrEn   = wr_en_reg;
  assign pix.wrAddr = wr_addr_reg;
  assign pix.wrData = wr_data_reg;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed, table-driven bench for pixel_frame_writer (6x6 frame, 3-bit pixels).
module tb_pixel_frame_writer;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic frameDone;

  int checks = 0;
  int errors = 0;

  pixel_frame_writer_if #(.colSz(3), .ADDR_BITS(6)) bus ();

  pixel_frame_writer #(
    .WIDTH     (6),
    .HEIGHT    (6),
    .colSz     (3),
    .THRESHOLD (0)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .busy      (busy),
    .frameDone (frameDone),
    .pix       (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       valid;
    logic [2:0] pix;
    logic       exp_ready;
    logic       exp_wren;
    logic [5:0] exp_addr;
    logic [2:0] exp_data;
    logic       exp_done;
  } vec_t;

  vec_t vecs[38];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected written data for a given pixel (THRESHOLD = 0).
  function automatic logic [2:0] expd(input logic [2:0] p);
`ifdef PIX_BINARISE_EN
    return (p > 3'd0) ? 3'd7 : 3'd0;
`else
    return p;
`endif
  endfunction

  task automatic drive(input logic s, input logic v, input logic [2:0] p);
    start        = s;
    bus.pixValid = v;
    bus.pixIn    = p;
  endtask

  initial begin
    int done_cnt;
    bus.pixValid = 1'b0;
    bus.pixIn    = '0;

    // Table: start, 36 back-to-back pixels, start during DONE, idle.
    vecs[0] = '{start: 1'b1, valid: 1'b0, pix: 3'd0, exp_ready: 1'b1,
                exp_wren: 1'b0, exp_addr: 6'd0, exp_data: 3'd0, exp_done: 1'b0};
    for (int i = 0; i < 36; i++) begin
      vecs[i+1] = '{start: 1'b0, valid: 1'b1, pix: 3'(i % 8),
                    exp_ready: (i != 35), exp_wren: 1'b1, exp_addr: 6'(i),
                    exp_data: expd(3'(i % 8)), exp_done: (i == 35)};
    end
    vecs[37] = '{start: 1'b1, valid: 1'b0, pix: 3'd0, exp_ready: 1'b0,
                 exp_wren: 1'b0, exp_addr: 6'd0, exp_data: 3'd0, exp_done: 1'b0};

    // Reset state.
    #2 resetn = 1'b0;
    #1;
    chk("rst_wren", bus.wrEn, 0);
    chk("rst_addr", bus.wrAddr, 0);
    chk("rst_data", bus.wrData, 0);
    chk("rst_ready", bus.pixReady, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frameDone, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_ready", bus.pixReady, 0);

    // Full frame from the table.
    done_cnt = 0;
    for (int k = 0; k < 38; k++) begin
      drive(vecs[k].start, vecs[k].valid, vecs[k].pix);
      @(negedge clk);
      $display("vec %0d: wrEn=%0d wrAddr=%0d wrData=%0d frameDone=%0d pixReady=%0d",
               k, bus.wrEn, bus.wrAddr, bus.wrData, frameDone, bus.pixReady);
      done_cnt += int'(frameDone);
      chk($sformatf("tbl%0d_ready", k), bus.pixReady, vecs[k].exp_ready);
      chk($sformatf("tbl%0d_wren", k), bus.wrEn, vecs[k].exp_wren);
      chk($sformatf("tbl%0d_done", k), frameDone, vecs[k].exp_done);
      if (vecs[k].exp_wren) begin
        chk($sformatf("tbl%0d_addr", k), bus.wrAddr, vecs[k].exp_addr);
        chk($sformatf("tbl%0d_data", k), bus.wrData, vecs[k].exp_data);
      end
      if (k == 7)  chk("seventh_addr", bus.wrAddr, 6);
      if (k == 12) chk("twelfth_addr", bus.wrAddr, 11);
    end
    chk("frame_done_count", done_cnt, 1);
    chk("after_frame_busy", busy, 0);

    // Alternating pixValid gaps.
    done_cnt = 0;
    drive(1'b1, 1'b0, 3'd0);
    @(negedge clk);
    chk("gap_start_ready", bus.pixReady, 1);
    for (int i = 0; i < 36; i++) begin
      drive(1'b0, 1'b1, 3'(i % 8));
      @(negedge clk);
      $display("gap pix %0d: wrEn=%0d wrAddr=%0d wrData=%0d", i, bus.wrEn, bus.wrAddr, bus.wrData);
      done_cnt += int'(frameDone);
      chk($sformatf("gap%0d_wren", i), bus.wrEn, 1);
      chk($sformatf("gap%0d_addr", i), bus.wrAddr, i);
      drive(1'b0, 1'b0, 3'd0);
      @(negedge clk);
      done_cnt += int'(frameDone);
      chk($sformatf("gap%0d_idle_wren", i), bus.wrEn, 0);
    end
    chk("gap_done_count", done_cnt, 1);

    // start mid-frame is ignored; reset after 20 pixels abandons the frame.
    drive(1'b1, 1'b0, 3'd0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      drive(i == 10, 1'b1, 3'(i % 8));
      @(negedge clk);
      $display("ign pix %0d: wrEn=%0d wrAddr=%0d", i, bus.wrEn, bus.wrAddr);
      chk($sformatf("ign%0d_addr", i), bus.wrAddr, i);
      chk($sformatf("ign%0d_done", i), frameDone, 0);
    end
    chk("pre_reset_wren", bus.wrEn, 1);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_wren", bus.wrEn, 0);
    chk("midrst_ready", bus.pixReady, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", frameDone, 0);
    @(negedge clk);
    chk("midrst_hold_done", frameDone, 0);
    drive(1'b0, 1'b0, 3'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("postrst_ready", bus.pixReady, 0);
    chk("postrst_done", frameDone, 0);

    // New frame after reset starts at address 0; data mapping check.
    drive(1'b1, 1'b0, 3'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0);
    @(negedge clk);
    $display("restart pix 0: wrEn=%0d wrAddr=%0d wrData=%0d", bus.wrEn, bus.wrAddr, bus.wrData);
    chk("restart_addr0", bus.wrAddr, 0);
    chk("restart_wren0", bus.wrEn, 1);
    chk("map_pix0", bus.wrData, 0);
    drive(1'b0, 1'b1, 3'd3);
    @(negedge clk);
    $display("restart pix 1: wrEn=%0d wrAddr=%0d wrData=%0d", bus.wrEn, bus.wrAddr, bus.wrData);
    chk("restart_addr1", bus.wrAddr, 1);
`ifdef PIX_BINARISE_EN
    chk("map_pix3", bus.wrData, 7);
`else
    chk("map_pix3", bus.wrData, 3);
`endif
    drive(1'b0, 1'b0, 3'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
